toy_fetch_filter: RTL and testbench

- Upstream neighbour of the fetch queue: takes one aligned I-cache fetch line per handshake and trims it to the predicted window [start, end].
- Compacts the surviving instructions into lanes 0..N-1 and presents them as a filter packet (filter_vld/filter_rdy/filter_pld/filter_en).
- Provides 2-entry elastic buffering so line_rdy never depends combinationally on filter_rdy.
- Drops stale lines after a flush using an epoch tag.

---
 rtl/toy_fetch_filter_pkg.sv | 24 ++
 rtl/toy_fetch_filter_if.sv | 39 +++
 rtl/toy_fetch_skid2.sv | 78 +++++++
 rtl/toy_fetch_filter.sv | 111 +++++++++++
 tb/tb_toy_fetch_filter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/toy_fetch_filter_pkg.sv
// Shared types and constants for the fetch filter slice: per-lane fetch queue
// payload, line geometry and the elastic buffer occupancy encoding.
package toy_pack;

  localparam int unsigned ADDR_WIDTH        = 32;
  localparam int unsigned INST_WIDTH_32     = 32;
  localparam int unsigned FILTER_CHANNEL    = 16;
  localparam int unsigned FETCH_EPOCH_WIDTH = 2;
  localparam int unsigned FETCH_LINE_BYTES  = FILTER_CHANNEL * 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    pc;
    logic [INST_WIDTH_32-1:0] inst;
    logic                     pred_taken;
    logic [ADDR_WIDTH-1:0]    pred_target;
  } fetch_queue_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_e;

endpackage

// File: rtl/toy_fetch_filter_if.sv
// Handshake bundles around the fetch filter: the incoming I-cache line
// (master = fetch, slave = filter) and the outgoing packet (master = filter).
interface toy_fetch_line_if import toy_pack::*; #(
  parameter int unsigned FC = FILTER_CHANNEL,
  parameter int unsigned EW = FETCH_EPOCH_WIDTH
) ();
  logic                       line_vld;
  logic                       line_rdy;
  logic [ADDR_WIDTH-1:0]      line_pc;
  logic [FC*INST_WIDTH_32-1:0] line_data;
  logic [$clog2(FC)-1:0]      line_start;
  logic [$clog2(FC)-1:0]      line_end;
  logic                       line_taken;
  logic [ADDR_WIDTH-1:0]      line_target;
  logic [EW-1:0]              line_epoch;

  modport master (
    output line_vld, line_pc, line_data, line_start, line_end,
           line_taken, line_target, line_epoch,
    input  line_rdy
  );
  modport slave (
    input  line_vld, line_pc, line_data, line_start, line_end,
           line_taken, line_target, line_epoch,
    output line_rdy
  );
endinterface

interface toy_fetch_pkt_if import toy_pack::*; #(
  parameter int unsigned FC = FILTER_CHANNEL
) ();
  logic           filter_vld;
  logic           filter_rdy;
  fetch_queue_pkg filter_pld [FC];
  logic [FC-1:0]  filter_en;

  modport master (output filter_vld, filter_pld, filter_en, input filter_rdy);
  modport slave  (input filter_vld, filter_pld, filter_en, output filter_rdy);
endinterface

// File: rtl/toy_fetch_skid2.sv
// Generic two-entry valid/ready elastic buffer (main + skid) with a
// synchronous clear; in_rdy is a pure state decode so it never sees out_rdy.
module toy_fetch_skid2 import toy_pack::*; #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_vld,
  output logic in_rdy,
  input  T     in_data,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_data
);

  skid_state_e state_q, state_d;
  T            main_q, main_d;
  T            skid_q, skid_d;
  logic        push, pop;

  assign in_rdy   = (state_q != SKID_TWO);
  assign out_vld  = (state_q != SKID_EMPTY);
  assign out_data = main_q;
  assign push     = in_vld && in_rdy;
  assign pop      = out_vld && out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clr) begin
      state_d = SKID_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = SKID_TWO;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          // in_rdy is low here, so a pop can only promote skid into main
          if (pop) begin
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/toy_fetch_filter.sv
// Trims an aligned fetch line to its predicted [start, end] window, compacts
// it into lanes 0..n-1, buffers two packets and drops stale-epoch lines.
module toy_fetch_filter
  import toy_pack::fetch_queue_pkg, toy_pack::ADDR_WIDTH, toy_pack::INST_WIDTH_32,
         toy_pack::FETCH_EPOCH_WIDTH;
#(
  parameter int unsigned FILTER_CHANNEL = toy_pack::FILTER_CHANNEL,
  parameter int unsigned EPOCH_WIDTH    = FETCH_EPOCH_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cancel_en,
  toy_fetch_line_if.slave           line,
  toy_fetch_pkt_if.master           filt,
  output logic [EPOCH_WIDTH-1:0]    epoch,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int unsigned LW = $clog2(FILTER_CHANNEL);

  typedef struct packed {
    fetch_queue_pkg [FILTER_CHANNEL-1:0] pld;
    logic [FILTER_CHANNEL-1:0]           en;
  } pkt_t;

  logic [INST_WIDTH_32-1:0]  slot [FILTER_CHANNEL];
  logic [ADDR_WIDTH-1:0]     base;
  logic [LW:0]               n;
  logic [LW:0]               idx;
  pkt_t                      pkt_in, pkt_out;
  logic [EPOCH_WIDTH-1:0]    epoch_q, epoch_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      accept, match, stale, store_vld;

  assign base = line.line_pc & ~(ADDR_WIDTH'(FILTER_CHANNEL * 4 - 1));
  assign n    = {1'b0, line.line_end} - {1'b0, line.line_start} + (LW+1)'(1);

  always_comb begin
    for (int unsigned s = 0; s < FILTER_CHANNEL; s++) begin
      slot[s] = line.line_data[s*INST_WIDTH_32 +: INST_WIDTH_32];
    end
  end

  // Lane k pulls slot start+k; end >= start keeps idx below FILTER_CHANNEL
  always_comb begin
    pkt_in = '0;
    idx    = '0;
    for (int unsigned k = 0; k < FILTER_CHANNEL; k++) begin
      idx = {1'b0, line.line_start} + (LW+1)'(k);
      if ((LW+1)'(k) < n) begin
        pkt_in.en[k]      = 1'b1;
        pkt_in.pld[k].inst = slot[idx[LW-1:0]];
        pkt_in.pld[k].pc   = base + ADDR_WIDTH'({idx, 2'b00});
        if ((LW+1)'(k) == n - (LW+1)'(1)) begin
          pkt_in.pld[k].pred_taken  = line.line_taken;
          pkt_in.pld[k].pred_target = line.line_target;
        end
      end
    end
  end

  assign accept    = line.line_vld && line.line_rdy;
  assign match     = (line.line_epoch == epoch_q);
  assign store_vld = line.line_vld && match && !cancel_en;
  assign stale     = accept && !match && !cancel_en;

  toy_fetch_skid2 #(.T(pkt_t)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clr      (cancel_en),
    .in_vld   (store_vld),
    .in_rdy   (line.line_rdy),
    .in_data  (pkt_in),
    .out_vld  (filt.filter_vld),
    .out_rdy  (filt.filter_rdy),
    .out_data (pkt_out)
  );

  assign filt.filter_en = pkt_out.en;

  always_comb begin
    for (int unsigned k = 0; k < FILTER_CHANNEL; k++) begin
      filt.filter_pld[k] = pkt_out.pld[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_q <= '0;
      drop_q  <= '0;
    end else begin
      epoch_q <= epoch_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    epoch_d = epoch_q;
    drop_d  = drop_q;
    if (cancel_en) begin
      epoch_d = epoch_q + EPOCH_WIDTH'(1);
    end else if (stale && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_WIDTH'(1);
    end
  end

  assign epoch    = epoch_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_toy_fetch_filter.sv
// Self-checking bench for toy_fetch_filter: directed window table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_toy_fetch_filter;
  import toy_pack::*;

  localparam int unsigned FC = 16;

  typedef struct packed {
    fetch_queue_pkg [FC-1:0] pld;
    logic [FC-1:0]           en;
  } pkt_t;

  typedef struct {
    logic [31:0] pc;
    int          start;
    int          stop;
    logic        taken;
    logic [31:0] tgt;
    logic [15:0] en;
    logic [31:0] pc0;
    logic [31:0] pclast;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, cancel_en, cancel_s;
  logic [1:0]  epoch, epoch_s;
  logic [15:0] drop_cnt;
  logic [2:0]  drop_s;

  toy_fetch_line_if lif ();
  toy_fetch_pkt_if  pif ();
  toy_fetch_line_if lif_s ();
  toy_fetch_pkt_if  pif_s ();

  always #5 clk = ~clk;

  toy_fetch_filter #(.FILTER_CHANNEL(16), .EPOCH_WIDTH(2), .DROP_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cancel_en(cancel_en), .line(lif), .filt(pif),
    .epoch(epoch), .drop_cnt(drop_cnt)
  );

  toy_fetch_filter #(.FILTER_CHANNEL(16), .EPOCH_WIDTH(2), .DROP_CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .cancel_en(cancel_s), .line(lif_s), .filt(pif_s),
    .epoch(epoch_s), .drop_cnt(drop_s)
  );

  pkt_t        mq[$];
  logic [1:0]  m_epoch;
  logic [15:0] m_drop;
  logic        last_acc;
  logic [31:0] dut_seen[$];
  int          checks, failures;
  vec_t        tv[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic pkt_t model_pkt(input logic [31:0] pc, input int start, input int stop,
                                     input logic taken, input logic [31:0] tgt,
                                     input logic [511:0] data);
    pkt_t        p;
    int          n;
    int          s;
    logic [31:0] base;
    p    = '0;
    n    = stop - start + 1;
    base = pc & 32'hFFFF_FFC0;
    for (int k = 0; k < n; k++) begin
      s = start + k;
      p.en[k]          = 1'b1;
      p.pld[k].inst    = data[32*s +: 32];
      p.pld[k].pc      = base + 32'(4 * s);
      if (k == n - 1) begin
        p.pld[k].pred_taken  = taken;
        p.pld[k].pred_target = tgt;
      end
    end
    return p;
  endfunction

  task automatic cmp_pkt(input string nm, input pkt_t exp);
    pkt_t act;
    act.en = pif.filter_en;
    for (int k = 0; k < FC; k++) act.pld[k] = pif.filter_pld[k];
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < FC; k++) begin
        if (act.pld[k] !== exp.pld[k] || act.en[k] !== exp.en[k]) begin
          $display("FAIL %s lane %0d: got en=%h pc=%h inst=%h tk=%b tgt=%h expected en=%h pc=%h inst=%h tk=%b tgt=%h",
                   nm, k, act.en, act.pld[k].pc, act.pld[k].inst, act.pld[k].pred_taken,
                   act.pld[k].pred_target, exp.en, exp.pld[k].pc, exp.pld[k].inst,
                   exp.pld[k].pred_taken, exp.pld[k].pred_target);
          break;
        end
      end
    end
  endtask

  // Compare against the model, advance the model with the current inputs, then clock.
  task automatic tick();
    logic pop, acc;
    chk("line_rdy", lif.line_rdy, mq.size() < 2);
    chk("filter_vld", pif.filter_vld, mq.size() > 0);
    if (mq.size() > 0) cmp_pkt("head_pkt", mq[0]);
    chk("epoch", epoch, m_epoch);
    chk("drop_cnt", drop_cnt, m_drop);
    if (pif.filter_vld && pif.filter_rdy) dut_seen.push_back(pif.filter_pld[0].pc);
    pop = (mq.size() > 0) && pif.filter_rdy;
    acc = lif.line_vld && (mq.size() < 2);
    if (cancel_en) begin
      mq.delete();
      m_epoch = m_epoch + 2'd1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (lif.line_epoch == m_epoch)
          mq.push_back(model_pkt(lif.line_pc, int'(lif.line_start), int'(lif.line_end),
                                 lif.line_taken, lif.line_target, lif.line_data));
        else if (m_drop != 16'hFFFF)
          m_drop = m_drop + 16'd1;
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic set_line(input logic [31:0] pc, input int start, input int stop,
                          input logic taken, input logic [31:0] tgt, input logic [1:0] ep,
                          input logic [511:0] data);
    lif.line_vld    = 1'b1;
    lif.line_pc     = pc;
    lif.line_start  = 4'(start);
    lif.line_end    = 4'(stop);
    lif.line_taken  = taken;
    lif.line_target = tgt;
    lif.line_epoch  = ep;
    lif.line_data   = data;
  endtask

  task automatic offer(input logic [31:0] pc, input int start, input int stop,
                       input logic [1:0] ep);
    set_line(pc, start, stop, 1'b1, pc + 32'h100, ep, rand_data());
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) tick();
    if (!last_acc) chk("offer_timeout", 64'd0, 64'd1);
    lif.line_vld = 1'b0;
  endtask

  initial begin
    logic [511:0] d;
    int           n;
    checks = 0; failures = 0;
    m_epoch = '0; m_drop = '0; last_acc = 1'b0;
    mq.delete(); dut_seen.delete();

    tv[0] = '{32'h0000_1000, 0, 15, 1'b0, 32'h0, 16'hFFFF, 32'h0000_1000, 32'h0000_103C};
    tv[1] = '{32'h0000_2000, 5, 9, 1'b1, 32'h4000, 16'h001F, 32'h0000_2014, 32'h0000_2024};
    tv[2] = '{32'h0000_3033, 15, 15, 1'b1, 32'h8, 16'h0001, 32'h0000_303C, 32'h0000_303C};
    tv[3] = '{32'h0000_0040, 3, 3, 1'b0, 32'h0, 16'h0001, 32'h0000_004C, 32'h0000_004C};
    tv[4] = '{32'h1234_5678, 0, 7, 1'b1, 32'hDEAD_BEE0, 16'h00FF, 32'h1234_5640, 32'h1234_565C};

    rst = 1'b1; cancel_en = 1'b0; cancel_s = 1'b0;
    lif.line_vld = 1'b0; lif.line_pc = '0; lif.line_data = '0; lif.line_start = '0;
    lif.line_end = '0; lif.line_taken = 1'b0; lif.line_target = '0; lif.line_epoch = '0;
    pif.filter_rdy = 1'b0;
    lif_s.line_vld = 1'b0; lif_s.line_pc = 32'h500; lif_s.line_data = '0;
    lif_s.line_start = 4'd2; lif_s.line_end = 4'd4; lif_s.line_taken = 1'b0;
    lif_s.line_target = '0; lif_s.line_epoch = 2'd1; pif_s.filter_rdy = 1'b1;

    #12;
    chk("rst_vld", pif.filter_vld, 0);
    chk("rst_en", pif.filter_en, 0);
    chk("rst_pld0", pif.filter_pld[0], 0);
    chk("rst_pld15", pif.filter_pld[15], 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_drop", drop_cnt, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_reset", lif.line_rdy, 1);

    // Directed window table
    pif.filter_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = rand_data();
      n = tv[i].stop - tv[i].start + 1;
      set_line(tv[i].pc, tv[i].start, tv[i].stop, tv[i].taken, tv[i].tgt, m_epoch, d);
      tick();
      lif.line_vld = 1'b0;
      chk("tbl_vld", pif.filter_vld, 1);
      chk("tbl_en", pif.filter_en, tv[i].en);
      chk("tbl_pc0", pif.filter_pld[0].pc, tv[i].pc0);
      chk("tbl_inst0", pif.filter_pld[0].inst, d[32*tv[i].start +: 32]);
      chk("tbl_pclast", pif.filter_pld[n-1].pc, tv[i].pclast);
      chk("tbl_taken", pif.filter_pld[n-1].pred_taken, tv[i].taken);
      chk("tbl_tgt", pif.filter_pld[n-1].pred_target, tv[i].taken ? tv[i].tgt : 32'h0);
      if (n > 1) chk("tbl_taken0", pif.filter_pld[0].pred_taken, 0);
      if (n < 16) chk("tbl_zero_lane", pif.filter_pld[n], 0);
      tick();
    end

    // Backpressure: A, B fill the buffer, C waits
    pif.filter_rdy = 1'b0;
    offer(32'hA000, 1, 6, m_epoch);
    offer(32'hB000, 0, 3, m_epoch);
    chk("bp_rdy_low", lif.line_rdy, 0);
    set_line(32'hC000, 4, 12, 1'b0, 32'h0, m_epoch, rand_data());
    tick(); tick();
    chk("bp_rdy_held", lif.line_rdy, 0);
    chk("bp_hold_a", pif.filter_pld[0].pc, 32'hA004);
    dut_seen.delete();
    pif.filter_rdy = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    if (!last_acc) chk("bp_c_timeout", 64'd0, 64'd1);
    lif.line_vld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_count", dut_seen.size(), 3);
    if (dut_seen.size() == 3) begin
      chk("bp_order_a", dut_seen[0], 32'hA004);
      chk("bp_order_b", dut_seen[1], 32'hB000);
      chk("bp_order_c", dut_seen[2], 32'hC010);
    end

    // Cancel with both entries full
    pif.filter_rdy = 1'b0;
    offer(32'h7000, 0, 15, m_epoch);
    offer(32'h7040, 2, 2, m_epoch);
    cancel_en = 1'b1;
    tick();
    cancel_en = 1'b0;
    chk("cancel_vld", pif.filter_vld, 0);
    chk("cancel_epoch", epoch, 1);
    chk("cancel_rdy", lif.line_rdy, 1);

    // Stale epoch lines are dropped
    pif.filter_rdy = 1'b1;
    dut_seen.delete();
    offer(32'h8000, 0, 1, 2'd0);
    offer(32'h8040, 0, 1, 2'd0);
    offer(32'h8080, 3, 5, 2'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("stale_drop", drop_cnt, 2);
    chk("stale_count", dut_seen.size(), 1);
    if (dut_seen.size() == 1) chk("stale_survivor", dut_seen[0], 32'h808C);

    // Line handshaken in the cancel cycle is discarded, not counted
    set_line(32'h9000, 0, 0, 1'b0, 32'h0, m_epoch + 2'd1, rand_data());
    cancel_en = 1'b1;
    tick();
    cancel_en = 1'b0; lif.line_vld = 1'b0;
    tick();
    chk("cancel_hs_drop", drop_cnt, 2);
    chk("cancel_hs_vld", pif.filter_vld, 0);

    // Epoch wrap
    for (int i = 0; i < 4 && m_epoch != 2'd0; i++) begin
      cancel_en = 1'b1; tick();
    end
    for (int i = 0; i < 4; i++) begin
      cancel_en = 1'b1; tick();
    end
    cancel_en = 1'b0;
    chk("epoch_wrap", epoch, 0);

    // Saturation on the narrow-counter instance
    lif_s.line_vld = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("sat_partial", drop_s, 3);
    for (int i = 0; i < 7; i++) tick();
    lif_s.line_vld = 1'b0;
    chk("sat_hold", drop_s, 7);
    chk("sat_vld", pif_s.filter_vld, 0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      int s, e;
      s = $urandom_range(0, 15);
      e = $urandom_range(s, 15);
      set_line($urandom, s, e, 1'($urandom), $urandom,
               ($urandom_range(0, 4) == 0) ? m_epoch - 2'd1 : m_epoch, rand_data());
      lif.line_vld   = ($urandom_range(0, 9) < 7);
      pif.filter_rdy = ($urandom_range(0, 9) < 6);
      cancel_en      = ($urandom_range(0, 24) == 0);
      tick();
    end
    lif.line_vld = 1'b0; cancel_en = 1'b0; pif.filter_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-stream while a packet is stalled
    cancel_en = 1'b1; tick(); cancel_en = 1'b0;
    offer(32'h6000, 1, 1, m_epoch + 2'd1);
    pif.filter_rdy = 1'b0;
    offer(32'h6100, 0, 9, m_epoch);
    chk("pre_rst_vld", pif.filter_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", pif.filter_vld, 0);
    chk("async_rst_en", pif.filter_en, 0);
    chk("async_rst_epoch", epoch, 0);
    chk("async_rst_drop", drop_cnt, 0);
    mq.delete(); m_epoch = '0; m_drop = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst2", lif.line_rdy, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
